// File: rtl/lsu_dmem.sv
`default_nettype none
// ============================================================================
// Module   : lsu_dmem
// Purpose  : RV32I load/store unit with private byte-addressable data memory,
//            lane select, sign/zero extension and fault detection.
// Revision : 1.0  initial release
// ============================================================================
module lsu_dmem #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic        fault_q, fault_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [AW-1:0] w_widx;
    logic [31:0]   w_rword;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_ldval;
    logic [3:0]    w_be;
    logic [31:0]   w_wword;
    logic [31:0]   w_merged;
    logic          w_fault;
    logic          w_wr_en;
    logic          w_accept;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            fault_q  <= fault_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_accept) state_d = ST_MEM;
            ST_MEM:  state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        req_ready = (state_q == ST_IDLE) && !reset;
        rsp_valid = (state_q == ST_RESP);
        rsp_rdata = rdata_q;
        rsp_fault = fault_q;
    end

    assign w_accept = req_valid && req_ready;

    // Fault classification on the captured request
    always_comb begin
        w_fault = |addr_q[31:AW+2];
        if (we_q) begin
            if (funct3_q > 3'd2) w_fault = 1'b1;
        end else if (funct3_q == 3'd3 || funct3_q == 3'd6 || funct3_q == 3'd7) begin
            w_fault = 1'b1;
        end
        if (funct3_q[1:0] == 2'd1 && addr_q[0])          w_fault = 1'b1;
        if (funct3_q[1:0] == 2'd2 && addr_q[1:0] != 2'd0) w_fault = 1'b1;
    end

    assign w_widx  = addr_q[AW+1:2];
    assign w_rword = mem_q[w_widx];

    always_comb begin
        case (addr_q[1:0])
            2'd0:    w_byte = w_rword[7:0];
            2'd1:    w_byte = w_rword[15:8];
            2'd2:    w_byte = w_rword[23:16];
            default: w_byte = w_rword[31:24];
        endcase
        w_half = addr_q[1] ? w_rword[31:16] : w_rword[15:0];
        case (funct3_q)
            3'd0:    w_ldval = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_ldval = {{16{w_half[15]}}, w_half};
            3'd4:    w_ldval = {24'd0, w_byte};
            3'd5:    w_ldval = {16'd0, w_half};
            default: w_ldval = w_rword;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target
    always_comb begin
        case (funct3_q[1:0])
            2'd0: begin
                w_be    = 4'b0001 << addr_q[1:0];
                w_wword = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                w_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                w_wword = {2{wdata_q[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wword = wdata_q;
            end
        endcase
        for (int b = 0; b < 4; b++) begin
            w_merged[8*b +: 8] = w_be[b] ? w_wword[8*b +: 8] : w_rword[8*b +: 8];
        end
    end

    assign w_wr_en = (state_q == ST_MEM) && we_q && !w_fault && !reset;

    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        if (w_accept) begin
            addr_d   = req_addr;
            wdata_d  = req_wdata;
            funct3_d = req_funct3;
            we_d     = req_we;
        end
        if (state_q == ST_MEM) begin
            fault_d = w_fault;
            rdata_d = (w_fault || we_q) ? 32'd0 : w_ldval;
        end
    end

    // Memory is deliberately outside the reset domain
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[w_widx] <= w_merged;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_dmem
// Purpose  : Self-checking bench for lsu_dmem against a byte-array model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu_dmem;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    int total = 0;
    int bad   = 0;

    logic [7:0] mb [0:1023];

    lsu_dmem #(.DEPTH_WORDS(256)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_fault(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        if (a >= 32'd1024) return 1'b1;
        if (we && f3 > 3'd2) return 1'b1;
        if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        sz = 1 << f3[1:0];
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
        int n;
        logic [31:0] v;
        n = 1 << f3[1:0];
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[a + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) mb[a + i] = d[8*i +: 8];
    endtask

    // One full transaction starting at a negedge; ends at a negedge.
    task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int hold, input bit stray,
                       output logic [31:0] got);
        int n;
        bit flt;
        logic [31:0] exp;
        logic [31:0] held_d;
        logic        held_f;
        flt = m_fault(we, f3, a);
        exp = (flt || we) ? 32'd0 : m_load(f3, a);
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
        @(negedge clk);
        chk("lat_mem", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("lat_rsp", 32'(rsp_valid), 32'd1);
        chk("rdata", rsp_rdata, exp);
        chk("fault", 32'(rsp_fault), 32'(flt));
        held_d = rsp_rdata;
        held_f = rsp_fault;
        for (int c = 0; c < hold; c++) begin
            if (stray) begin
                req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
                req_addr = 32'h10; req_wdata = 32'h0;
            end
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, held_d);
            chk("bp_fault", 32'(rsp_fault), 32'(held_f));
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("retire_valid", 32'(rsp_valid), 32'd0);
        chk("retire_ready", 32'(req_ready), 32'd1);
        if (we && !flt) m_store(f3, a, wd);
        got = held_d;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        bit          w;
        logic [2:0]  f;
        for (int i = 0; i < 1024; i++) mb[i] = 8'd0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_fault", 32'(rsp_fault), 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_ready", 32'(req_ready), 32'd1);
        @(negedge clk);

        // Clear the region used below
        for (int i = 0; i < 64; i++) txn(1'b1, 3'd2, 32'(i * 4), 32'd0, 0, 1'b0, got);

        // Word store/load and extensions
        txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 1'b0, got);
        txn(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0, got); chk("lw_10", got, 32'hDEADBEEF);
        txn(1'b0, 3'd0, 32'h13, 32'h0, 0, 1'b0, got); chk("lb_13", got, 32'hFFFFFFDE);
        txn(1'b0, 3'd4, 32'h13, 32'h0, 0, 1'b0, got); chk("lbu_13", got, 32'h000000DE);
        txn(1'b0, 3'd1, 32'h12, 32'h0, 0, 1'b0, got); chk("lh_12", got, 32'hFFFFDEAD);
        txn(1'b0, 3'd5, 32'h10, 32'h0, 0, 1'b0, got); chk("lhu_10", got, 32'h0000BEEF);

        // Partial stores
        txn(1'b1, 3'd2, 32'h20, 32'h11223344, 0, 1'b0, got);
        txn(1'b1, 3'd0, 32'h21, 32'hFFFFFFAA, 0, 1'b0, got);
        txn(1'b1, 3'd1, 32'h22, 32'hFFFF5566, 0, 1'b0, got);
        txn(1'b0, 3'd2, 32'h20, 32'h0, 0, 1'b0, got); chk("lw_20", got, 32'h5566AA44);

        // Faults
        txn(1'b0, 3'd2, 32'h22, 32'h0, 0, 1'b0, got);
        txn(1'b1, 3'd1, 32'h21, 32'hFFFF, 0, 1'b0, got);
        txn(1'b0, 3'd3, 32'h10, 32'h0, 0, 1'b0, got);
        txn(1'b1, 3'd2, 32'h400, 32'hCAFEF00D, 0, 1'b0, got);
        txn(1'b0, 3'd2, 32'h0, 32'h0, 0, 1'b0, got); chk("word0_kept", got, 32'h0);

        // Backpressure with a stray store request that must be ignored
        txn(1'b0, 3'd2, 32'h10, 32'h0, 5, 1'b1, got);
        txn(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0, got); chk("stray_ignored", got, 32'hDEADBEEF);

        // Reset during MEM of a store
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h30; req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);
        txn(1'b0, 3'd2, 32'h30, 32'h0, 0, 1'b0, got); chk("lw_30_old", got, 32'h0);

        // Randomized traffic against the byte model
        for (int i = 0; i < 150; i++) begin
            w = 1'($urandom);
            f = 3'($urandom);
            case ($urandom % 8)
                0: a = 32'h400 + ($urandom % 1024);
                1: a = $urandom;
                default: a = $urandom_range(0, 255);
            endcase
            txn(w, f, a, $urandom, $urandom % 3, 1'b0, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_dmem.md
# lsu_dmem

Load/store unit with private byte-addressable data memory, sitting directly downstream of the core's execute stage. It services RV32I loads (lb, lh, lw, lbu, lhu) and stores (sb, sh, sw). Each access is one request/response transaction over a valid/ready handshake. The unit performs byte-lane selection, sign or zero extension, byte-enable writes, and alignment and range checking, so the core sees a finished 32-bit register value or a fault flag.

## Interface
- DEPTH_WORDS, 256, data memory depth in 32-bit words (1024 bytes by default); power of two.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept; high only in IDLE and while reset is low.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3. Loads: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu. Stores: 0 sb, 1 sh, 2 sw.
- req_addr  input  32  byte address (rs1 + imm, already computed by the core).
- req_wdata  input  32  store data (rs2); low bytes used for sb/sh.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core consumes response.
- rsp_rdata  output  32  extended load result; 0 for stores and faults.
- rsp_fault  output  1  access rejected (misaligned, out of range, or illegal funct3).

## Operation
- FSM states: IDLE, MEM, RESP.
  - IDLE -> MEM on req_valid && req_ready. addr, we, funct3 and wdata are captured into registers.
  - MEM -> RESP unconditionally.
  - RESP -> IDLE on rsp_ready.
- Fault check is done on the captured request in MEM. Fault if any of:
  - word index addr[31:2] >= DEPTH_WORDS;
  - lh/lhu/sh with addr[0] = 1;
  - lw/sw with addr[1:0] != 0;
  - funct3 in {3, 6, 7} for a load, or funct3 > 2 for a store.
- Faulting access: no memory write; rsp_rdata = 0; rsp_fault = 1. Latency is the same as a normal access.
- Load: the word at addr[31:2] is read in MEM, then lane-selected.
  - lb/lbu use byte addr[1:0]; lb sign-extends bit 7, lbu zero-extends.
  - lh/lhu use halfword addr[1]; lh sign-extends bit 15, lhu zero-extends.
  - lw returns the full word.
- Store: writes happen at the MEM-exit edge, with byte enables.
  - sb writes wdata[7:0] to lane addr[1:0].
  - sh writes wdata[15:0] to halfword addr[1].
  - sw writes the whole word.
  - Unselected bytes are preserved.
  - Response carries rsp_rdata = 0, rsp_fault = 0.
- Memory contents are not cleared by reset. The simulation initial value is all zero.

## Timing
- Reset values: FSM = IDLE; rsp_valid = 0; rsp_rdata = 0; rsp_fault = 0; req_ready = 0 while reset is high, then 1 in the first cycle after release.
- Request accepted at edge k. Memory is accessed at edge k+1. rsp_valid is high from edge k+1 onward. rsp_rdata and rsp_fault are registered and held stable while rsp_valid && !rsp_ready.
- Response retires at the first edge with rsp_valid && rsp_ready. req_ready rises in the following cycle. The earliest next accept is 1 cycle after retire, giving a minimum of 3 cycles per access.
- Requests presented outside IDLE are ignored. The core must hold them until req_ready is high.
- A load issued after a store response to the same word returns the stored data. There is no forwarding hazard, since the write completes before that store's rsp_valid.
- Reset asserted mid-transaction:
  - The FSM goes to IDLE immediately and the response is dropped.
  - A store in MEM whose write edge coincides with, or follows, reset assertion is not performed.
  - A store already past MEM stays written.
- rsp_ready held high with no response pending has no effect.

## Test plan
- Store/load word: sw addr 0x10, data 0xDEADBEEF; lw 0x10 -> rsp_rdata 0xDEADBEEF, fault 0, rsp_valid exactly 2 edges after accept.
- Byte/half extension, using word 0xDEADBEEF at 0x10:
  - lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE.
  - lh 0x12 -> 0xFFFFDEAD; lhu 0x10 -> 0x0000BEEF.
- Partial stores: sw 0x20 = 0x11223344, then sb 0x21 data 0xAA, then sh 0x22 data 0x5566; lw 0x20 -> 0x5566AA44.
- Faults:
  - lw 0x22, sh 0x21 and load funct3 = 3 -> rsp_fault 1, rdata 0.
  - sw to 0x400 (DEPTH_WORDS 256) -> fault, and memory word 0 is unchanged afterward.
- Backpressure: hold rsp_ready low for 5 cycles -> rsp_valid, rsp_rdata and rsp_fault stay stable; req_ready stays 0; a new req_valid during this window is not accepted.
- Reset mid-store: accept sw 0x30 = 0x12345678, assert reset during MEM -> FSM returns to IDLE, rsp_valid 0; after release, lw 0x30 returns the old value (0).
